// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every signal between the two cache requesters, the arbiter and
// the shared four-bank memory port.
//
// Requester side (per cache, prefix i_ / d_):
//   x_req              request, held high for a whole evict+fill transaction
//   x_addr, x_data_in  address and write data (16 bit)
//   x_wr, x_rd         write / read strobes
//   x_gnt              registered grant back to the requester
//   x_data_out, x_err  read data and error returned to the requester
//   x_stall, x_busy    stall and 4-bit bank-busy view
// Memory side:
//   m_addr, m_data_in, m_wr, m_rd     request port driven by the arbiter
//   m_data_out, m_busy, m_stall, m_err response port driven by memory
//
// Handshake: x_req behaves as a "valid" that stays high until the requester
// is finished; x_gnt is the matching "ready". Strobes on x_wr/x_rd only reach
// memory in cycles where x_gnt is high, and a grant is never withdrawn while
// x_req remains high.
//
// Modports: slave = the arbiter, master = the environment (caches + memory).
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        i_req;
    logic        d_req;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [15:0] i_data_in;
    logic [15:0] d_data_in;
    logic        i_wr;
    logic        i_rd;
    logic        d_wr;
    logic        d_rd;

    logic        i_gnt;
    logic        d_gnt;
    logic [15:0] i_data_out;
    logic [15:0] d_data_out;
    logic        i_stall;
    logic        d_stall;
    logic        i_err;
    logic        d_err;
    logic [3:0]  i_busy;
    logic [3:0]  d_busy;

    logic [15:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_wr;
    logic        m_rd;
    logic [15:0] m_data_out;
    logic [3:0]  m_busy;
    logic        m_stall;
    logic        m_err;

    modport slave (
        input  i_req, d_req, i_addr, d_addr, i_data_in, d_data_in,
               i_wr, i_rd, d_wr, d_rd,
               m_data_out, m_busy, m_stall, m_err,
        output i_gnt, d_gnt, i_data_out, d_data_out, i_stall, d_stall,
               i_err, d_err, i_busy, d_busy,
               m_addr, m_data_in, m_wr, m_rd
    );

    modport master (
        output i_req, d_req, i_addr, d_addr, i_data_in, d_data_in,
               i_wr, i_rd, d_wr, d_rd,
               m_data_out, m_busy, m_stall, m_err,
        input  i_gnt, d_gnt, i_data_out, d_data_out, i_stall, d_stall,
               i_err, d_err, i_busy, d_busy,
               m_addr, m_data_in, m_wr, m_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one four-bank memory port between an
// instruction cache (i) and a data cache (d).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   bus        mem_arbiter_if.slave, requester and memory signals
//   dbg_state  current FSM state (0 IDLE, 1 GNT_I, 2 GNT_D, 3 DRAIN)
//
// Parameter:
//   MEM_LAT    cycles from access issue until read data/err is valid (2..15)
//
// Operation: a granted requester keeps the port until it drops its request.
// The port then drains for at least MEM_LAT cycles and until memory reports
// no busy bank, so late read data still reaches the previous owner before
// the port is handed on (straight to the next grant if someone is waiting).
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Last drain cycle: counter value MEM_LAT-1 means MEM_LAT cycles spent.
    localparam logic [3:0] CNT_END = 4'(MEM_LAT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic       last_d_q;   // last owner: 0 = I-cache, 1 = D-cache

    logic       any_req;
    logic       pick_d;
    logic       drain_done;
    logic       i_conflict;
    logic       d_conflict;

    assign dbg_state = state_q;

    // Round-robin: with both requesting, the one that did not own the port
    // last wins; a lone requester always wins.
    assign any_req    = bus.i_req | bus.d_req;
    assign pick_d     = bus.d_req & (~bus.i_req | ~last_d_q);
    assign drain_done = (cnt_q == CNT_END) && (bus.m_busy == 4'b0000);

    assign i_conflict = bus.i_wr & bus.i_rd;
    assign d_conflict = bus.d_wr & bus.d_rd;

    // -----------------------------------------------------------------------
    // State register (plus drain counter and last-owner pointer)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_GNT_I: begin
                    if (!bus.i_req) begin
                        cnt_q    <= 4'd0;
                        last_d_q <= 1'b0;
                    end
                end
                S_GNT_D: begin
                    if (!bus.d_req) begin
                        cnt_q    <= 4'd0;
                        last_d_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Hold at the end value while memory is still busy so the
                    // exit condition cannot be missed by wrapping.
                    if (cnt_q != CNT_END) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = pick_d ? S_GNT_D : S_GNT_I;
                end
            end
            S_GNT_I: begin
                if (!bus.i_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_GNT_D: begin
                if (!bus.d_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    if (any_req) begin
                        state_d = pick_d ? S_GNT_D : S_GNT_I;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Non-owner view for both requesters, memory port quiet.
        bus.i_gnt      = 1'b0;
        bus.d_gnt      = 1'b0;
        bus.i_stall    = 1'b1;
        bus.d_stall    = 1'b1;
        bus.i_data_out = 16'h0000;
        bus.d_data_out = 16'h0000;
        bus.i_err      = 1'b0;
        bus.d_err      = 1'b0;
        bus.i_busy     = 4'b1111;
        bus.d_busy     = 4'b1111;
        bus.m_addr     = 16'h0000;
        bus.m_data_in  = 16'h0000;
        bus.m_wr       = 1'b0;
        bus.m_rd       = 1'b0;

        case (state_q)
            S_GNT_I: begin
                bus.i_gnt      = 1'b1;
                bus.m_addr     = bus.i_addr;
                bus.m_data_in  = bus.i_data_in;
                // Simultaneous write and read is illegal: suppress both.
                bus.m_wr       = bus.i_wr & ~i_conflict;
                bus.m_rd       = bus.i_rd & ~i_conflict;
                bus.i_stall    = bus.m_stall;
                bus.i_busy     = bus.m_busy;
                bus.i_data_out = bus.m_data_out;
                bus.i_err      = bus.m_err | i_conflict;
            end
            S_GNT_D: begin
                bus.d_gnt      = 1'b1;
                bus.m_addr     = bus.d_addr;
                bus.m_data_in  = bus.d_data_in;
                bus.m_wr       = bus.d_wr & ~d_conflict;
                bus.m_rd       = bus.d_rd & ~d_conflict;
                bus.d_stall    = bus.m_stall;
                bus.d_busy     = bus.m_busy;
                bus.d_data_out = bus.m_data_out;
                bus.d_err      = bus.m_err | d_conflict;
            end
            S_DRAIN: begin
                // In-flight read data belongs to the previous owner.
                if (last_d_q) begin
                    bus.d_data_out = bus.m_data_out;
                    bus.d_err      = bus.m_err;
                end else begin
                    bus.i_data_out = bus.m_data_out;
                    bus.i_err      = bus.m_err;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4, memory cycles from an access issue until its read data/err is valid; legal range 2..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req, d_req  input  1 each  instruction-/data-cache request; held high for the whole transaction (evict plus fill sequence).
REQ-005 i_addr, d_addr, i_data_in, d_data_in  input  16 each  requester address and write data.
REQ-006 i_wr, i_rd, d_wr, d_rd  input  1 each  requester write/read strobes.
REQ-007 i_gnt, d_gnt  output  1 each  registered grant; exactly one or none high.
REQ-008 i_data_out, d_data_out  output  16 each  read data returned to the requester.
REQ-009 i_stall, d_stall, i_err, d_err  output  1 each  per-requester stall and error.
REQ-010 i_busy, d_busy  output  4 each  per-requester bank-busy view.
REQ-011 m_addr, m_data_in  output  16 each;  m_wr, m_rd  output  1 each  shared four-bank memory request port.
REQ-012 m_data_out  input  16;  m_busy  input  4;  m_stall, m_err  input  1 each  shared memory response port.

Function
REQ-013 States: IDLE, GNT_I, GNT_D, DRAIN; 1-bit last-owner pointer; DRAIN counter 4 bits.
REQ-014 IDLE: no request -> stay; request(s) present -> next cycle GNT_I or GNT_D per REQ-015 (grant latency exactly one cycle).
REQ-015 Arbitration round-robin: both requesting -> requester not equal to last owner wins; single requester always wins.
REQ-016 GNT_x: stay while x_req high; x_req low -> DRAIN, counter loaded 0, last owner := x.
REQ-017 Grant is never revoked while its req is high, regardless of the other requester.
REQ-018 In GNT_x, m_addr/m_data_in/m_wr/m_rd driven from x combinationally; x_stall=m_stall, x_busy=m_busy, x_data_out=m_data_out, x_err=m_err.
REQ-019 Owner asserting x_wr and x_rd together: m_wr=m_rd=0 and x_err=1 that cycle.
REQ-020 DRAIN: m_wr=m_rd=0; x_data_out and x_err still routed to last owner so in-flight read data is delivered; counter increments each cycle.
REQ-021 DRAIN exits when counter reaches MEM_LAT-1 and m_busy==4'b0000; else stays; then next state chosen per REQ-014/REQ-015 (direct GNT_x without passing IDLE).
REQ-022 Non-owner (and both in IDLE): stall=1, data_out=16'h0000, err=0, busy=4'b1111; its wr/rd ignored, never reach memory.
REQ-023 IDLE: m_addr=m_data_in=0, m_wr=m_rd=0.
REQ-024 Simultaneous i_req and d_req rising in IDLE right after reset -> d-cache wins (pointer reset value = I).
REQ-025 Requester dropping req and re-raising in same DRAIN: treated as new request at DRAIN exit; round-robin still applies.

Reset
REQ-026 rst high: immediately (asynchronously) state IDLE, counter 0, pointer = I, i_gnt=d_gnt=0, m_wr=m_rd=0, all outputs per REQ-022/REQ-023.
REQ-027 Reset mid-transaction (any state) aborts it with no further memory strobes; first grant possible one cycle after rst deasserts.

Verification
REQ-028 Reset, then d_req=1 alone at cycle 0 -> d_gnt=1 at cycle 1, i_stall=1, i_data_out=0.
REQ-029 Both req high after reset -> d_gnt first; d_req drops at cycle 10 -> DRAIN 4 cycles (MEM_LAT=4, m_busy=0) -> i_gnt=1 at cycle 15.
REQ-030 Owner D reads addr 16'h0040, drops req next cycle -> m_data_out=16'hBEEF arriving during DRAIN appears on d_data_out, not i_data_out.
REQ-031 Owner I drives i_wr=i_rd=1 -> m_wr=m_rd=0, i_err=1 that cycle only.
REQ-032 DRAIN with m_busy=4'b0010 held 3 cycles past counter end -> no grant until m_busy==0; i_wr pulsed by non-owner never appears on m_wr.
REQ-033 rst pulsed while GNT_I with i_wr=1 -> m_wr=0 and i_gnt=0 within the same cycle, state IDLE after release.
